mux2to1_rr_arbiter: RTL



---
 rtl/mux_pkg.sv | 16 +
 rtl/mux2to1_rr_arbiter_sat_counter.sv | 38 +++
 rtl/mux2to1_rr_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and constants for the 2:1 round-robin arbiter.
//   SEL_A / SEL_B : channel encodings used for sel, prio and out_src
//   src_t         : one-bit channel identifier
//   other_src()   : returns the opposite channel
package mux_pkg;

  typedef logic src_t;

  localparam src_t SEL_A = 1'b0;
  localparam src_t SEL_B = 1'b1;

  function automatic src_t other_src(input src_t s);
    return ~s;
  endfunction

endpackage

// File: rtl/mux2to1_rr_arbiter_sat_counter.sv
// Saturating up-counter used to count accepted transfers per channel.
//   clk : clock, rising edge
//   rst : synchronous active-high reset, clears the count
//   inc : increment request for this cycle
//   cnt : current count, sticks at all-ones
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Increment unless already at the ceiling
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mux2to1_rr_arbiter.sv
// Two-channel round-robin arbiter with a single-entry registered output stage.
// Drives the select of the downstream 2:1 mux and records the winning payload.
//   clk, rst               : clock, synchronous active-high reset
//   a_valid/a_data/a_ready : channel A producer handshake
//   b_valid/b_data/b_ready : channel B producer handshake
//   sel                    : combinational grant (0 = A, 1 = B), prio when idle
//   out_valid/out_data/out_src/out_ready : registered consumer handshake
//   a_cnt, b_cnt           : saturating accepted-transfer counts
module mux2to1_rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] a_cnt,
  output logic [CNT_W-1:0] b_cnt
);

  src_t             prio_q,      prio_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  src_t             out_src_q,   out_src_d;

  src_t grant;
  logic can_load;
  logic a_acc;
  logic b_acc;
  logic accept;

  // Grant selection: a lone requester wins, contention goes to prio
  always_comb begin
    grant = prio_q;
    if (a_valid && !b_valid) begin
      grant = SEL_A;
    end else if (b_valid && !a_valid) begin
      grant = SEL_B;
    end
  end

  // Output slot is free if empty or being drained this cycle
  assign can_load = !out_valid_q || out_ready;

  // Readies are suppressed during reset so nothing is handed off that would be dropped
  assign a_acc  = !rst && can_load && a_valid && (grant == SEL_A);
  assign b_acc  = !rst && can_load && b_valid && (grant == SEL_B);
  assign accept = a_acc || b_acc;

  assign a_ready = a_acc;
  assign b_ready = b_acc;
  assign sel     = rst ? SEL_A : grant;

  // Output register and priority next-state
  always_comb begin
    prio_d      = prio_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = (grant == SEL_B) ? b_data : a_data;
      out_src_d   = grant;
      prio_d      = other_src(grant);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q      <= SEL_A;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= SEL_A;
    end else begin
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

  sat_counter #(.CNT_W(CNT_W)) u_a_cnt (
    .clk (clk),
    .rst (rst),
    .inc (a_acc),
    .cnt (a_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_b_cnt (
    .clk (clk),
    .rst (rst),
    .inc (b_acc),
    .cnt (b_cnt)
  );

endmodule
